offchip_arbiter: RTL and testbench

Shares the single off-chip memory port between three cache-line requesters: port 0 is I-cache refill, port 1 is D-cache refill/writeback, port 2 is aux (DMA/debug). It arbitrates round-robin and runs one full line transfer at a time. It drives the off-chip read/write enables and holds them until the memory ready signal arrives. A watchdog aborts transfers that never complete.

---
 rtl/offchip_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_offchip_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/offchip_arbiter.sv
// Round-robin arbiter sharing one off-chip memory port between I-cache, D-cache and aux
// requesters; runs one full line transfer at a time with a ready watchdog.
module offchip_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req,
    input  logic [2:0]          we,
    input  logic [3*ADDR_W-1:0] addr,
    input  logic [3*LINE_W-1:0] wdata,
    output logic [2:0]          ack,
    output logic                err,
    output logic [LINE_W-1:0]   rdata,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic [ADDR_W-1:0]   offchip_mem_addr,
    output logic [LINE_W-1:0]   offchip_mem_wdata,
    output logic                offchip_mem_read_en,
    output logic                offchip_mem_write_en,
    input  logic [LINE_W-1:0]   offchip_mem_data,
    input  logic                offchip_mem_ready,
    output logic [1:0]          dbg_state
);

    // Handshake: req[i] is a level held with addr/we/wdata stable until ack[i] pulses for one
    // cycle; the requester drops req the cycle after ack or a fresh transfer is started.
    // Toward memory, read_en/write_en stay high until offchip_mem_ready completes the line.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT != 0);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(15);

    state_e             state_q, state_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         ack_q, ack_d;
    logic               err_q, err_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic [1:0]         grant_q, grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic               rd_en_q, rd_en_d;
    logic               wr_en_q, wr_en_d;

    logic [1:0]         pri0, pri1, pri2;
    logic [1:0]         win;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LINE_W-1:0]  sel_wdata;
    logic [2:0]         grant_oh;

    // Search starts at the port after the last one served, wrapping 2 -> 0.
    always_comb begin
        pri0 = 2'd0;
        pri1 = 2'd1;
        pri2 = 2'd2;
        case (last_grant_q)
            2'd0: begin pri0 = 2'd1; pri1 = 2'd2; pri2 = 2'd0; end
            2'd1: begin pri0 = 2'd2; pri1 = 2'd0; pri2 = 2'd1; end
            default: begin pri0 = 2'd0; pri1 = 2'd1; pri2 = 2'd2; end
        endcase
        if (req[pri0]) begin
            win = pri0;
        end else if (req[pri1]) begin
            win = pri1;
        end else begin
            win = pri2;
        end
        sel_addr  = addr[win*ADDR_W +: ADDR_W];
        sel_wdata = wdata[win*LINE_W +: LINE_W];
        grant_oh  = 3'b000;
        grant_oh[grant_q] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ack_d        = ack_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_BUSY;
                    grant_d = win;
                    addr_d  = sel_addr & ALIGN_MASK;
                    wdata_d = sel_wdata;
                    wr_en_d = we[win];
                    rd_en_d = ~we[win];
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (offchip_mem_ready) begin
                    rd_en_d      = 1'b0;
                    wr_en_d      = 1'b0;
                    if (rd_en_q) begin
                        rdata_d = offchip_mem_data;
                    end
                    ack_d        = grant_oh;
                    err_d        = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = ST_DONE;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    // Watchdog: complete with err so the requester is never stranded.
                    rd_en_d      = 1'b0;
                    wr_en_d      = 1'b0;
                    ack_d        = grant_oh;
                    err_d        = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                ack_d   = 3'b000;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 2'd2;
            cnt_q        <= '0;
            ack_q        <= 3'b000;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            grant_q      <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
        end
    end

    assign ack                  = ack_q;
    assign err                  = err_q;
    assign rdata                = rdata_q;
    assign grant_id             = grant_q;
    assign busy                 = (state_q != ST_IDLE);
    assign offchip_mem_addr     = addr_q;
    assign offchip_mem_wdata    = wdata_q;
    assign offchip_mem_read_en  = rd_en_q;
    assign offchip_mem_write_en = wr_en_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_offchip_arbiter.sv
// Bench for offchip_arbiter: directed vector table, hand-written corner sequences and a
// randomized phase checked against a transaction-level round-robin model.
module tb_offchip_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 255;

    logic                clk, rst;
    logic [2:0]          req, we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*LINE_W-1:0] wdata;
    logic [2:0]          ack;
    logic                err;
    logic [LINE_W-1:0]   rdata;
    logic [1:0]          grant_id;
    logic                busy;
    logic [ADDR_W-1:0]   offchip_mem_addr;
    logic [LINE_W-1:0]   offchip_mem_wdata;
    logic                offchip_mem_read_en, offchip_mem_write_en;
    logic [LINE_W-1:0]   offchip_mem_data;
    logic                offchip_mem_ready;
    logic [1:0]          dbg_state;

    int checks = 0;
    int errors = 0;

    offchip_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .grant_id(grant_id), .busy(busy),
        .offchip_mem_addr(offchip_mem_addr), .offchip_mem_wdata(offchip_mem_wdata),
        .offchip_mem_read_en(offchip_mem_read_en), .offchip_mem_write_en(offchip_mem_write_en),
        .offchip_mem_data(offchip_mem_data), .offchip_mem_ready(offchip_mem_ready),
        .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder / model state
    bit                rand_mode = 0;
    bit                mon_en = 0;
    bit                force_ready = 0;
    int                dir_lat = 0;
    logic [LINE_W-1:0] dir_data = '0;
    int                n_busy = 0;
    int                last_busy = 0;
    int                cur_lat = 0;
    logic [LINE_W-1:0] cur_data = '0;
    logic [2:0]        req_prev = 3'b000;
    int                model_last = 2;
    logic [LINE_W-1:0] model_rdata = '0;
    logic [134:0]      exp_q[$];
    int                n_rise = 0;
    int                n_ack = 0;
    int                st[3];
    bit [2:0]          ackd = 3'b000;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return 3;
    endfunction

    task automatic monitor_grant();
        int  w;
        bit  e_err;
        int  e_busy;
        w = rr_pick(model_last, req_prev);
        chk("rr_winner", grant_id, w);
        if (w < 3) begin
            chk("rnd_mem_addr", offchip_mem_addr, {addr[w*ADDR_W+4 +: ADDR_W-4], 4'b0000});
            chk("rnd_mem_wdata", offchip_mem_wdata, wdata[w*LINE_W +: LINE_W]);
            chk("rnd_write_en", offchip_mem_write_en, we[w]);
            chk("rnd_read_en", offchip_mem_read_en, !we[w]);
            e_err  = (cur_lat >= TIMEOUT);
            e_busy = e_err ? TIMEOUT : cur_lat + 1;
            if (!we[w] && !e_err) model_rdata = cur_data;
            exp_q.push_back({4'(e_busy), 2'(w), e_err, model_rdata});
            model_last = w;
        end
        n_rise++;
        if (grant_id < 3) st[grant_id] = 2;
    endtask

    task automatic monitor_ack();
        logic [134:0] e;
        if (exp_q.size() == 0) begin
            chk("ack_unexpected", ack, 3'b000);
        end else begin
            e = exp_q.pop_front();
            chk("rnd_ack", ack, 3'b001 << e[130:129]);
            chk("rnd_err", err, e[128]);
            chk("rnd_rdata", rdata, e[127:0]);
            chk("rnd_busy_cycles", last_busy, e[134:131]);
            chk("rnd_en_off", {offchip_mem_read_en, offchip_mem_write_en}, 2'b00);
            n_ack++;
        end
        for (int i = 0; i < 3; i++) if (ack[i]) ackd[i] = 1'b1;
    endtask

    // Memory side: answers each transfer after a chosen number of BUSY cycles
    initial begin
        offchip_mem_ready = 1'b0;
        offchip_mem_data  = '0;
        forever begin
            @(negedge clk);
            if (offchip_mem_read_en || offchip_mem_write_en) begin
                if (n_busy == 0) begin
                    if (rand_mode) begin
                        cur_lat = $urandom_range(0, 9);
                        if (cur_lat == 9) cur_lat = NEVER;
                        cur_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                    end else begin
                        cur_lat  = dir_lat;
                        cur_data = dir_data;
                    end
                    offchip_mem_data = cur_data;
                    if (mon_en) monitor_grant();
                end
                offchip_mem_ready = (n_busy == cur_lat);
                n_busy++;
            end else begin
                if (n_busy != 0) last_busy = n_busy;
                n_busy = 0;
                offchip_mem_ready = force_ready || (rand_mode && $urandom_range(0, 5) == 0);
                if (mon_en && ack != 3'b000) monitor_ack();
            end
            if (mon_en) begin
                chk("en_exclusive", offchip_mem_read_en & offchip_mem_write_en, 1'b0);
                chk("ack_onehot", ($countones(ack) <= 1), 1'b1);
            end
            req_prev = req;
        end
    end

    task automatic wait_rise(input int bound, output bit seen, output int cyc);
        seen = 0;
        cyc  = bound;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (offchip_mem_read_en || offchip_mem_write_en) begin
                seen = 1;
                cyc  = k;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int bound, output bit seen, output int nb);
        seen = 0;
        nb   = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                seen = 1;
                break;
            end
            if (offchip_mem_read_en || offchip_mem_write_en) nb++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        req = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int                port;
        logic              wr;
        logic [31:0]       a;
        logic [127:0]      wd;
        int                lat;
        logic [127:0]      md;
        bit                drop;
        logic [31:0]       e_addr;
        logic [2:0]        e_ack;
        logic              e_err;
        logic [127:0]      e_rdata;
        int                e_busy;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        bit seen;
        int cyc, nb;
        @(posedge clk);
        #1;
        dir_lat  = v.lat;
        dir_data = v.md;
        addr[v.port*ADDR_W +: ADDR_W]  = v.a;
        wdata[v.port*LINE_W +: LINE_W] = v.wd;
        we[v.port] = v.wr;
        req = 3'b000;
        req[v.port] = 1'b1;
        wait_rise(5, seen, cyc);
        chk("rise_latency", cyc, 1);
        if (!seen) begin
            req = 3'b000;
            return;
        end
        chk("read_en", offchip_mem_read_en, !v.wr);
        chk("write_en", offchip_mem_write_en, v.wr);
        chk("mem_addr", offchip_mem_addr, v.e_addr);
        chk("mem_wdata", offchip_mem_wdata, v.wd);
        chk("grant_id", grant_id, v.port);
        chk("busy_xfer", busy, 1'b1);
        if (v.drop) begin
            @(posedge clk);
            #1 req[v.port] = 1'b0;
        end
        wait_ack(20, seen, nb);
        chk("ack_seen", seen, 1'b1);
        chk("ack", ack, v.e_ack);
        chk("err", err, v.e_err);
        chk("rdata", rdata, v.e_rdata);
        chk("busy_cycles", nb + 1, v.e_busy);
        chk("en_off_at_ack", {offchip_mem_read_en, offchip_mem_write_en}, 2'b00);
        chk("busy_done", busy, 1'b1);
        @(posedge clk);
        #1 req = 3'b000;
        @(negedge clk);
        chk("ack_clear", {ack, err}, 4'b0000);
        chk("idle_after", busy, 1'b0);
    endtask

    task automatic step_requesters(input bit gen);
        for (int i = 0; i < 3; i++) begin
            if (ackd[i]) begin
                req[i]  = 1'b0;
                st[i]   = 0;
                ackd[i] = 1'b0;
            end else if (st[i] == 0) begin
                if (gen && $urandom_range(0, 2) == 0) begin
                    addr[i*ADDR_W +: ADDR_W]  = $urandom();
                    wdata[i*LINE_W +: LINE_W] = {$urandom(), $urandom(), $urandom(), $urandom()};
                    we[i]  = 1'($urandom_range(0, 1));
                    req[i] = 1'b1;
                    st[i]  = 1;
                end
            end else if (st[i] == 2 && req[i] && $urandom_range(0, 15) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        bit seen;
        int cyc, nb;
        logic [127:0] d0, a5, x3, cf, gd, s5;
        d0 = {4{32'hDEADBEEF}};
        a5 = {16{8'hA5}};
        x3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        cf = {4{32'hCAFEF00D}};
        gd = {4{32'h600DD00D}};
        s5 = {16{8'h5A}};
        vecs[0] = '{0, 1'b0, 32'h0000_1234, 128'h0, 2, d0, 1'b0, 32'h0000_1230, 3'b001, 1'b0, d0, 3};
        vecs[1] = '{1, 1'b1, 32'hABCD_EF0F, a5, 0, 128'h1111, 1'b0, 32'hABCD_EF00, 3'b010, 1'b0, d0, 1};
        vecs[2] = '{2, 1'b0, 32'h8000_0008, 128'h0, NEVER, 128'h2222, 1'b0, 32'h8000_0000, 3'b100, 1'b1, d0, 8};
        vecs[3] = '{2, 1'b0, 32'hFFFF_FFFF, 128'h0, 7, x3, 1'b0, 32'hFFFF_FFF0, 3'b100, 1'b0, x3, 8};
        vecs[4] = '{0, 1'b1, 32'h0000_0010, s5, 8, 128'h3333, 1'b0, 32'h0000_0010, 3'b001, 1'b1, x3, 8};
        vecs[5] = '{2, 1'b0, 32'h4444_444C, 128'h0, 3, cf, 1'b1, 32'h4444_4440, 3'b100, 1'b0, cf, 4};
        vecs[6] = '{1, 1'b0, 32'h0000_002F, 128'h0, 0, gd, 1'b0, 32'h0000_0020, 3'b010, 1'b0, gd, 1};
        for (int i = 0; i < 3; i++) st[i] = 0;

        rst = 1'b0;
        req = 3'b000;
        we = 3'b000;
        addr = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_err", {ack, err}, 4'b0000);
        chk("rst_rdata", rdata, 128'h0);
        chk("rst_grant_busy", {grant_id, busy}, 3'b000);
        chk("rst_mem_addr", offchip_mem_addr, 32'h0);
        chk("rst_mem_wdata", offchip_mem_wdata, 128'h0);
        chk("rst_enables", {offchip_mem_read_en, offchip_mem_write_en}, 2'b00);
        @(negedge clk);
        rst = 1'b1;

        // memory ready while idle must not start or complete anything
        @(posedge clk);
        #1 force_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready_busy", busy, 1'b0);
            chk("idle_ready_ack", ack, 3'b000);
        end
        #1 force_ready = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // contention: all three requesting, each drops for one cycle after its ack
        do_reset();
        dir_lat = 1;
        dir_data = 128'h77;
        we = 3'b000;
        @(posedge clk);
        #1 req = 3'b111;
        for (int j = 0; j < 6; j++) begin
            wait_ack(30, seen, nb);
            chk("cont_ack_seen", seen, 1'b1);
            chk("cont_order", ack, 3'b001 << (j % 3));
            chk("cont_onehot", $countones(ack), 1);
            chk("cont_grant", grant_id, j % 3);
            @(posedge clk);
            #1 req[j % 3] = 1'b0;
            @(posedge clk);
            #1 req[j % 3] = 1'b1;
        end
        req = 3'b000;
        repeat (4) @(posedge clk);

        // reset in the middle of a transfer
        dir_lat = NEVER;
        @(posedge clk);
        #1 req = 3'b010;
        wait_rise(5, seen, cyc);
        chk("mid_rise", seen, 1'b1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_enables", {offchip_mem_read_en, offchip_mem_write_en}, 2'b00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ack", ack, 3'b000);
        req = 3'b011;
        dir_lat = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ack", ack, 3'b000);
        end
        rst = 1'b1;
        wait_rise(5, seen, cyc);
        chk("post_rst_rise", seen, 1'b1);
        chk("post_rst_grant", grant_id, 2'd0);
        wait_ack(20, seen, nb);
        chk("post_rst_ack0", ack, 3'b001);
        @(posedge clk);
        #1 req[0] = 1'b0;
        wait_ack(20, seen, nb);
        chk("post_rst_ack1", ack, 3'b010);
        @(posedge clk);
        #1 req = 3'b000;
        repeat (3) @(posedge clk);

        // randomized traffic against the transaction model
        do_reset();
        model_last  = 2;
        model_rdata = '0;
        rand_mode   = 1;
        mon_en      = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1 step_requesters(1'b1);
        end
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1 step_requesters(1'b0);
            if (st[0] == 0 && st[1] == 0 && st[2] == 0 && !busy && req == 3'b000) begin
                seen = 1;
                break;
            end
        end
        chk("drain_done", seen, 1'b1);
        @(negedge clk);
        mon_en = 0;
        rand_mode = 0;
        chk("exp_q_empty", exp_q.size(), 0);
        chk("ack_per_grant", n_ack, n_rise);
        chk("enough_traffic", (n_ack > 100), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
